acc_result_packer: RTL and testbench



---
 rtl/acc_pkg.sv | 52 +++++
 rtl/acc_result_packer_if.sv | 12 +
 rtl/res_fifo.sv | 56 +++++
 rtl/acc_result_packer.sv | 123 ++++++++++++
 tb/tb_acc_result_packer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared configuration, FSM state type, result payload and round/saturate helper
// for the accumulator result packer.
package acc_pkg;

    localparam int unsigned ACC_W     = 32;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned SHIFT     = 8;
    localparam int unsigned RES_DEPTH = 4;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned CNT_W     = LEN_W;
    localparam int unsigned RES_W     = OUT_W + 1;
    localparam int unsigned FIFO_CW   = $clog2(RES_DEPTH) + 1;
    localparam int unsigned EXT_W     = ACC_W + 1;

    // Saturation bounds expressed in the widened rounding domain
    localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_CLR
    } state_t;

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] data;
    } res_t;

    // Round half-up, arithmetic shift, clamp to OUT_W; one extra bit keeps the add from wrapping
    function automatic res_t round_sat(input logic signed [ACC_W-1:0] acc,
                                       input int unsigned shift);
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] rnd;
        res_t                    res;
        ext = {acc[ACC_W-1], acc};
        rnd = (shift > 0) ? (EXT_W'(1) << (shift - 1)) : '0;
        ext = (ext + rnd) >>> shift;
        if (ext > OUT_MAX) begin
            res.sat  = 1'b1;
            res.data = OUT_MAX[OUT_W-1:0];
        end else if (ext < OUT_MIN) begin
            res.sat  = 1'b1;
            res.data = OUT_MIN[OUT_W-1:0];
        end else begin
            res.sat  = 1'b0;
            res.data = ext[OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/acc_result_packer_if.sv
// Result stream from the packer to its consumer (valid/ready handshake).
interface acc_result_packer_if #(
    parameter int unsigned OUT_W = 16
);
    logic [OUT_W-1:0] res_data;
    logic             res_sat;
    logic             res_valid;
    logic             res_ready;

    modport master (output res_data, output res_sat, output res_valid, input res_ready);
    modport slave  (input res_data, input res_sat, input res_valid, output res_ready);
endinterface

// File: rtl/res_fifo.sv
// Small first-word-fall-through FIFO; head is valid the cycle after a write.
module res_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     not_empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot, so a push to a full FIFO is still taken
    always_comb begin
        do_pop    = pop && (count != '0);
        do_push   = push && ((count != CW'(DEPTH)) || do_pop);
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem       <= '{default: '0};
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            not_empty <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            not_empty <= (count_nxt != '0);
        end
    end

    assign head = mem[rd_ptr];
    assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/acc_result_packer.sv
// Counts accumulator beats per vector, rounds/saturates the final sum, clears the
// accumulator and queues packed results for a valid/ready consumer.
module acc_result_packer
    import acc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ACC_W-1:0]     acc_in,
    input  logic                 acc_valid,
    input  logic [LEN_W-1:0]     cfg_vec_len,
    output logic                 acc_clr,
    acc_result_packer_if.master  res,
    output logic                 stall,
    output logic                 overflow
);
    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   len_nxt;
    logic               capture;
    logic               acc_clr_nxt;
    res_t               push_data;
    res_t               head;
    logic [RES_W-1:0]   head_raw;
    logic               fifo_valid;
    logic               fifo_full;
    logic [FIFO_CW-1:0] fifo_count;
    logic               pop;

    // State and beat-counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            len     <= '0;
            acc_clr <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            len     <= len_nxt;
            acc_clr <= acc_clr_nxt;
        end
    end

    // Next state; beats arriving during the clear cycle are ignored
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len;
        case (state)
            S_IDLE: begin
                if (acc_valid) begin
                    len_nxt   = (cfg_vec_len == '0) ? CNT_W'(1) : cfg_vec_len;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = (len_nxt == CNT_W'(1)) ? S_CLR : S_ACC;
                end
            end
            S_ACC: begin
                if (acc_valid) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt_nxt == len) begin
                        state_nxt = S_CLR;
                    end
                end
            end
            S_CLR: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture on the final beat; the clear pulse is registered into the following cycle
    always_comb begin
        capture     = 1'b0;
        acc_clr_nxt = 1'b0;
        push_data   = round_sat(acc_in, SHIFT);
        if ((state != S_CLR) && (state_nxt == S_CLR)) begin
            capture     = 1'b1;
            acc_clr_nxt = 1'b1;
        end
    end

    assign pop = fifo_valid && res.res_ready;

    res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (push_data),
        .pop       (pop),
        .head      (head_raw),
        .not_empty (fifo_valid),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign head          = head_raw;
    assign res.res_valid = fifo_valid;
    assign res.res_data  = head.data;
    assign res.res_sat   = head.sat;

    // Backpressure flag and sticky drop indicator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            stall    <= (fifo_count >= FIFO_CW'(RES_DEPTH - 1));
            overflow <= overflow | (capture & fifo_full & ~pop);
        end
    end

endmodule

// File: tb/tb_acc_result_packer.sv
// Directed bench for acc_result_packer with a queue-based reference model.
module tb_acc_result_packer;
    import acc_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [ACC_W-1:0] acc_in = '0;
    logic             acc_valid = 1'b0;
    logic [LEN_W-1:0] cfg_vec_len = '0;
    logic             acc_clr;
    logic             stall;
    logic             overflow;

    acc_result_packer_if #(.OUT_W(OUT_W)) rif();

    acc_result_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .acc_in      (acc_in),
        .acc_valid   (acc_valid),
        .cfg_vec_len (cfg_vec_len),
        .acc_clr     (acc_clr),
        .res         (rif),
        .stall       (stall),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int clr_pulses = 0;
    bit checking = 1'b0;

    // Reference model state
    int           m_len = 0;
    int           m_cnt = 0;
    bit           m_clr = 1'b0;
    bit           m_stall = 1'b0;
    bit           m_ovf = 1'b0;
    bit           m_pop;
    bit           m_push;
    logic [OUT_W:0] m_val;
    logic [OUT_W:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // floor((a + 128) / 256), clamped to 16-bit signed
    function automatic logic [OUT_W:0] model_res(input logic [31:0] a);
        longint v;
        longint qd;
        v  = longint'($signed(a)) + 128;
        qd = v / 256;
        if ((v % 256) != 0 && v < 0) qd = qd - 1;
        if (qd > 32767)  return {1'b1, 16'h7FFF};
        if (qd < -32768) return {1'b1, 16'h8000};
        return {1'b0, qd[15:0]};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_len   = 0;
            m_cnt   = 0;
            m_clr   = 1'b0;
            m_stall = 1'b0;
            m_ovf   = 1'b0;
            q.delete();
        end else begin
            m_stall = (q.size() >= 3);
            m_pop   = (q.size() != 0) && rif.res_ready;
            m_push  = 1'b0;
            if (m_clr) begin
                m_clr = 1'b0;
            end else if (acc_valid) begin
                if (m_cnt == 0) m_len = (cfg_vec_len == 0) ? 1 : int'(cfg_vec_len);
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_push = 1'b1;
                    m_val  = model_res(acc_in);
                    m_cnt  = 0;
                    m_clr  = 1'b1;
                end
            end
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                if (q.size() < RES_DEPTH) q.push_back(m_val);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("acc_clr", 32'(acc_clr), 32'(m_clr));
            chk("res_valid", 32'(rif.res_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("res_data", 32'(rif.res_data), 32'(q[0][OUT_W-1:0]));
                chk("res_sat", 32'(rif.res_sat), 32'(q[0][OUT_W]));
            end
            chk("stall", 32'(stall), 32'(m_stall));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (acc_clr) clr_pulses++;
        end
    end

    task automatic beat(input logic [31:0] v, input logic [7:0] len);
        @(negedge clk);
        acc_valid   = 1'b1;
        acc_in      = v;
        cfg_vec_len = len;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            acc_valid = 1'b0;
        end
    endtask

    int c0;

    initial begin
        rif.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        checking = 1'b1;
        chk("rst_acc_clr", 32'(acc_clr), 32'd0);
        chk("rst_res_valid", 32'(rif.res_valid), 32'd0);
        chk("rst_res_data", 32'(rif.res_data), 32'd0);
        chk("rst_res_sat", 32'(rif.res_sat), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // 1: four-beat vector
        c0 = clr_pulses;
        beat(32'd100, 8'd4);
        beat(32'd300, 8'd4);
        beat(32'd600, 8'd4);
        beat(32'd1000, 8'd4);
        idle(1);
        chk("t1_clr", 32'(acc_clr), 32'd1);
        chk("t1_valid", 32'(rif.res_valid), 32'd1);
        chk("t1_data", 32'(rif.res_data), 32'd4);
        chk("t1_sat", 32'(rif.res_sat), 32'd0);
        idle(1);
        chk("t1_drained", 32'(rif.res_valid), 32'd0);
        chk("t1_clr_low", 32'(acc_clr), 32'd0);
        idle(2);
        chk("t1_clr_pulses", 32'(clr_pulses - c0), 32'd1);

        // 2: single beat, negative floor
        beat(32'hFFFF_FC18, 8'd1);
        idle(1);
        chk("t2_clr", 32'(acc_clr), 32'd1);
        chk("t2_data", 32'(rif.res_data), 32'h0000_FFFC);
        chk("t2_sat", 32'(rif.res_sat), 32'd0);
        idle(2);

        // 3: positive and negative saturation
        beat(32'd5, 8'd2);
        beat(32'h7FFF_FFFF, 8'd2);
        idle(1);
        chk("t3_pos_data", 32'(rif.res_data), 32'h0000_7FFF);
        chk("t3_pos_sat", 32'(rif.res_sat), 32'd1);
        idle(1);
        beat(32'd5, 8'd2);
        beat(32'h8000_0000, 8'd2);
        idle(1);
        chk("t3_neg_data", 32'(rif.res_data), 32'h0000_8000);
        chk("t3_neg_sat", 32'(rif.res_sat), 32'd1);
        idle(2);

        // 4: length zero acts as one
        beat(32'd256, 8'd0);
        idle(1);
        chk("t4_clr", 32'(acc_clr), 32'd1);
        chk("t4_data", 32'(rif.res_data), 32'd1);
        chk("t4_sat", 32'(rif.res_sat), 32'd0);
        idle(2);

        // 5: fill with consumer stalled, then drain
        rif.res_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            beat(32'(k * 256), 8'd1);
            idle(1);
        end
        idle(2);
        chk("t5_overflow", 32'(overflow), 32'd1);
        chk("t5_stall", 32'(stall), 32'd1);
        chk("t5_valid", 32'(rif.res_valid), 32'd1);
        chk("t5_head", 32'(rif.res_data), 32'd1);
        rif.res_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t5_drain_valid", 32'(rif.res_valid), 32'd1);
            chk("t5_drain_data", 32'(rif.res_data), 32'(k));
            @(negedge clk);
        end
        chk("t5_empty", 32'(rif.res_valid), 32'd0);
        chk("t5_stall_clear", 32'(stall), 32'd0);
        chk("t5_overflow_held", 32'(overflow), 32'd1);

        // 6: reset mid-vector
        beat(32'd100, 8'd4);
        beat(32'd300, 8'd4);
        @(negedge clk);
        acc_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_overflow", 32'(overflow), 32'd0);
        chk("t6_rst_valid", 32'(rif.res_valid), 32'd0);
        chk("t6_rst_data", 32'(rif.res_data), 32'd0);
        chk("t6_rst_clr", 32'(acc_clr), 32'd0);
        chk("t6_rst_stall", 32'(stall), 32'd0);
        beat(32'd100, 8'd4);
        beat(32'd300, 8'd4);
        beat(32'd600, 8'd4);
        @(negedge clk);
        chk("t6_no_early_valid", 32'(rif.res_valid), 32'd0);
        chk("t6_no_early_clr", 32'(acc_clr), 32'd0);
        acc_valid = 1'b1;
        acc_in    = 32'd1000;
        @(negedge clk);
        acc_valid = 1'b0;
        chk("t6_clr", 32'(acc_clr), 32'd1);
        chk("t6_valid", 32'(rif.res_valid), 32'd1);
        chk("t6_data", 32'(rif.res_data), 32'd4);
        idle(3);
        chk("t6_single_result", 32'(rif.res_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
